key_expansion: RTL and testbench

- Sequential AES-128 key schedule. Takes a 128-bit cipher key and produces the 1408-bit expanded key, which holds 11 round keys.
- Sits directly upstream of addroundkey and drives its key input.
- Computes one 32-bit word per cycle with 4 S-box lookups, instead of unrolling the whole schedule combinationally.
- finish tells the consumer that the expanded key is complete and stable.

---
 rtl/key_expansion.sv | 87 ++++++++
 tb/tb_key_expansion.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
// key_expansion: sequential AES-128 key schedule, one 32-bit word per cycle.
// S-box is computed algebraically (GF(2^8) inverse followed by the affine map).
module key_expansion (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [127:0]  key_in,
  output logic [1407:0] key,
  output logic          finish
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] w_q [44];
  logic [31:0] w_d [44];
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [31:0] prev, rot, temp;
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    cnt_d = cnt_q;
    rcon_d = rcon_q;
    prev = w_q[cnt_q - 6'd1];
    rot = {prev[23:0], prev[31:24]};
    temp = (cnt_q[1:0] == 2'd0) ?
           {sbox(rot[31:24]) ^ rcon_q, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} : prev;
    case (state_q)
      IDLE: if (start) begin
        w_d[0] = key_in[127:96];
        w_d[1] = key_in[95:64];
        w_d[2] = key_in[63:32];
        w_d[3] = key_in[31:0];
        cnt_d = 6'd4;
        rcon_d = 8'h01;
        state_d = EXPAND;
      end
      EXPAND: begin
        w_d[cnt_q] = w_q[cnt_q - 6'd4] ^ temp;
        cnt_d = cnt_q + 6'd1;
        rcon_d = (cnt_q[1:0] == 2'd0) ? xtime(rcon_q) : rcon_q;
        state_d = (cnt_q == 6'd43) ? DONE : EXPAND;
      end
      DONE: state_d = start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rcon_q <= 8'h01;
      for (int i = 0; i < 44; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rcon_q <= rcon_d;
      w_q <= w_d;
    end
  end
  for (genvar g = 0; g < 44; g++) begin : g_key
    assign key[1407-32*g -: 32] = w_q[g];
  end
  assign finish = (state_q == DONE);
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: directed checks of the AES-128 key schedule against
// FIPS-197 and a second known-answer vector, plus latency/retrigger/reset cases.
module tb_key_expansion;
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [127:0]  key_in;
  logic [1407:0] key;
  logic          finish;
  int            total = 0;
  int            bad = 0;
  int            lat;
  int            held;

  localparam logic [127:0] KA     = 128'h65787061_6E642033_322D6279_7465206B;
  localparam logic [127:0] KA_R1  = 128'h29CF0FF3_47AB2FC0_75864DB9_01E36DD2;
  localparam logic [127:0] KA_R10 = 128'h782A7509_F13D5661_2EA71A58_15280270;
  localparam logic [127:0] ARK_ST = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] ARK_R5 = 128'h37F90453_1837E855_5351CD6C_75A2944E;
  localparam logic [127:0] KB     = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;
  localparam logic [127:0] KB_R1  = 128'hA0FAFE17_88542CB1_23A33939_2A6C7605;
  localparam logic [127:0] KB_R10 = 128'hD014F9A8_C9EE2589_E13F0CC8_B6630CA6;

  key_expansion dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .key_in (key_in),
    .key    (key),
    .finish (finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1407:0] obs, input logic [1407:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller has start=1; the first edge here is the capture edge N.
  task automatic run_expand(input bit busy, output int l);
    tick();
    check("in_expand_finish", finish, 0);
    l = 0;
    for (int i = 1; i <= 60 && l == 0; i++) begin
      if (busy) begin
        start = i[0];
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      if (finish) l = i;
    end
    start = 1'b1;
  endtask

  function automatic logic [127:0] round_key(input logic [1407:0] k, input int r);
    return k[1407-128*r -: 128];
  endfunction

  function automatic logic [31:0] word(input logic [1407:0] k, input int i);
    return k[1407-32*i -: 32];
  endfunction

  initial begin
    rst = 1'b0;
    start = 1'b1;
    key_in = KB;
    #23;
    check("rst_key", key, '0);
    check("rst_finish", finish, 0);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (10) tick();
    check("idle_key", key, '0);
    check("idle_finish", finish, 0);

    key_in = KA;
    start = 1'b1;
    run_expand(1'b0, lat);
    check("a_latency", lat, 40);
    check("a_round0", round_key(key, 0), KA);
    check("a_round1", round_key(key, 1), KA_R1);
    check("a_round10", round_key(key, 10), KA_R10);
    check("a_ark5", round_key(key, 5) ^ ARK_ST, ARK_R5 ^ ARK_ST ^ ARK_ST);
    check("a_ark5_result", ARK_ST ^ round_key(key, 5), ARK_R5);

    held = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (finish) held++;
    end
    check("done_hold_finish", held, 20);
    check("done_hold_key", round_key(key, 10), KA_R10);

    start = 1'b0;
    tick();
    check("drop_finish", finish, 0);
    check("drop_key_kept", round_key(key, 10), KA_R10);
    key_in = KB;
    start = 1'b1;
    run_expand(1'b0, lat);
    check("b_latency", lat, 40);
    check("b_w4", word(key, 4), 32'hA0FAFE17);
    check("b_w43", word(key, 43), 32'hB6630CA6);
    check("b_round1", round_key(key, 1), KB_R1);
    check("b_round10", round_key(key, 10), KB_R10);
    check("b_round0", round_key(key, 0), KB);

    start = 1'b0;
    tick();
    key_in = KA;
    start = 1'b1;
    run_expand(1'b1, lat);
    check("busy_latency", lat, 40);
    check("busy_round1", round_key(key, 1), KA_R1);
    check("busy_round10", round_key(key, 10), KA_R10);

    start = 1'b0;
    tick();
    key_in = KB;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    #2;
    rst = 1'b0;
    #1;
    check("midrst_key", key, '0);
    check("midrst_finish", finish, 0);
    @(negedge clk);
    rst = 1'b1;
    key_in = KA;
    start = 1'b1;
    run_expand(1'b0, lat);
    check("restart_latency", lat, 40);
    check("restart_round1", round_key(key, 1), KA_R1);
    check("restart_round10", round_key(key, 10), KA_R10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
